// File: rtl/tx_framer_pkg.sv
// Shared types and defaults for the QPSK TX framer.
// Frame order: preamble, 32-bit sync word, payload, inter-frame gap.
package tx_framer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSync,
        StPayload,
        StGap
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE_DEF = 8'hCC;
    localparam logic [31:0] SYNC_WORD_DEF     = 32'h1ACFFC1D;

    // Byte idx of the sync word, MSB byte first.
    function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dibit_serializer.sv
// Byte-to-dibit shifter: holds one byte and presents its dibits MSB-first.
// A load overrides a shift in the same cycle, giving back-to-back bytes without a bubble.
module dibit_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic [1:0] dibit,
    output logic       loaded,
    output logic       last_dibit
);

    logic [7:0] sr_q, sr_d;
    logic       loaded_q, loaded_d;
    logic [1:0] dcnt_q, dcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= 8'h00;
            loaded_q <= 1'b0;
            dcnt_q   <= 2'd0;
        end else begin
            sr_q     <= sr_d;
            loaded_q <= loaded_d;
            dcnt_q   <= dcnt_d;
        end
    end

    always_comb begin
        sr_d     = sr_q;
        loaded_d = loaded_q;
        dcnt_d   = dcnt_q;
        if (load) begin
            sr_d     = load_data;
            loaded_d = 1'b1;
            dcnt_d   = 2'd0;
        end else if (shift) begin
            sr_d   = {sr_q[5:0], 2'b00};
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) begin
                loaded_d = 1'b0;
            end
        end
    end

    assign dibit      = sr_q[7:6];
    assign loaded     = loaded_q;
    assign last_dibit = (dcnt_q == 2'd3);

endmodule

// File: rtl/tx_framer.sv
// Frames an AXI-Stream byte payload into QPSK dibits for TX_path_top:
// preamble, sync word, payload MSB-first, then an idle gap.
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
    parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEF,
    parameter int unsigned GAP_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_i,
    output logic        out_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam logic [3:0] PreLast = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        last_held_q, last_held_d;
    logic        first_q, first_d;
    logic        stall_q, stall_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic       ser_load;
    logic [7:0] ser_data;
    logic [1:0] dibit;
    logic       loaded;
    logic       last_dibit;
    logic       hs;
    logic       end_byte;
    logic       accept;
    logic       underrun_cond;

    dibit_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_data  (ser_data),
        .shift      (hs),
        .dibit      (dibit),
        .loaded     (loaded),
        .last_dibit (last_dibit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 4'd0;
            gap_cnt_q   <= 8'd0;
            last_held_q <= 1'b0;
            first_q     <= 1'b0;
            stall_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_held_q <= last_held_d;
            first_q     <= first_d;
            stall_q     <= stall_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_held_d = last_held_q;
        first_d     = first_q;
        frame_cnt_d = frame_cnt_q;
        stall_d     = underrun_cond;
        ser_load    = 1'b0;
        ser_data    = in_data;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ser_load   = 1'b1;
                    ser_data   = PREAMBLE_BYTE;
                    byte_cnt_d = 4'd0;
                    state_d    = StPreamble;
                end
            end
            StPreamble: begin
                if (end_byte) begin
                    ser_load = 1'b1;
                    if (byte_cnt_q == PreLast) begin
                        ser_data   = sync_byte(SYNC_WORD, 2'd0);
                        byte_cnt_d = 4'd0;
                        state_d    = StSync;
                    end else begin
                        ser_data   = PREAMBLE_BYTE;
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            StSync: begin
                if (end_byte) begin
                    if (byte_cnt_q == 4'd3) begin
                        state_d     = StPayload;
                        first_d     = 1'b1;
                        last_held_d = 1'b0;
                        if (accept) begin
                            ser_load    = 1'b1;
                            first_d     = 1'b0;
                            last_held_d = in_last;
                        end
                    end else begin
                        ser_load   = 1'b1;
                        ser_data   = sync_byte(SYNC_WORD, byte_cnt_q[1:0] + 2'd1);
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            StPayload: begin
                if (end_byte && last_held_q) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = 8'd0;
                    state_d     = (GAP_CYCLES == 0) ? StIdle : StGap;
                end else if (accept) begin
                    ser_load    = 1'b1;
                    first_d     = 1'b0;
                    last_held_d = in_last;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            StPreamble: out_valid = loaded;
            // First payload byte is taken on the final sync dibit so the boundary has no bubble.
            StSync: begin
                out_valid = loaded;
                in_ready  = loaded && last_dibit && out_ready && (byte_cnt_q == 4'd3);
            end
            StPayload: begin
                out_valid = loaded;
                in_ready  = (!loaded || (last_dibit && out_ready)) && !last_held_q;
            end
            default: ;
        endcase
        hs            = out_valid && out_ready;
        end_byte      = hs && last_dibit;
        accept        = in_valid && in_ready;
        // Before the first payload byte an empty serializer is not a starvation event.
        underrun_cond = (state_q == StPayload) && in_ready && !in_valid && !loaded && !first_q;
        underrun      = underrun_cond && !stall_q;
        busy          = (state_q != StIdle);
    end

    assign out_i     = dibit[1];
    assign out_q     = dibit[0];
    assign frame_cnt = frame_cnt_q;

endmodule
